// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART frame parser.
// Frame format: SYNC, CMD, LEN, LEN payload bytes, XOR checksum.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_HOLD    = 3'd5
    } state_e;

    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hAA;
    localparam int unsigned MAX_LEN_DEF   = 16;
    localparam int unsigned CHK_W         = 8;
    localparam int unsigned BUF_DEPTH     = 16;

    // Running checksum step: fold one received byte into the accumulator
    function automatic logic [CHK_W-1:0] chk_fold(input logic [CHK_W-1:0] acc,
                                                  input logic [7:0]       b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// 16x8 payload store for the frame parser: one write port, one registered read port.
// Storage is not reset; only the read register clears.
module uart_frame_buf
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [3:0] waddr,
    input  logic [7:0] wdata,
    input  logic [3:0] raddr,
    output logic [7:0] rdata
);

    logic [7:0] mem [BUF_DEPTH];
    logic [7:0] rdata_q;
    logic [7:0] rdata_d;

    // Payload storage write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data selection
    always_comb begin
        rdata_d = mem[raddr];
    end

    // Registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 8'h00;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Byte-stream frame parser: SYNC, CMD, LEN, payload, XOR checksum; holds one checked frame.
// Optional inter-byte timeout enabled by defining UART_PARSER_TIMEOUT_EN.
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEF,
    parameter int unsigned MAX_LEN        = MAX_LEN_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_frame_error,
    output logic       frm_avail,
    output logic [7:0] frm_cmd,
    output logic [4:0] frm_len,
    input  logic       frm_ack,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_frame,
    output logic       err_ovr
);

    state_e           state_q, state_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [4:0]       len_q, len_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CHK_W-1:0] chk_q, chk_d;
    logic             frm_avail_q, frm_avail_d;
    logic [7:0]       frm_cmd_q, frm_cmd_d;
    logic [4:0]       frm_len_q, frm_len_d;
    logic             err_chk_q, err_chk_d;
    logic             err_len_q, err_len_d;
    logic             err_frame_q, err_frame_d;
    logic             err_ovr_q, err_ovr_d;
    logic             buf_we_s;
    logic             tmo_fire_s;

`ifdef UART_PARSER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             tmo_run_s;

    // Idle counter while a frame is in progress; fires after TIMEOUT_CYCLES silent cycles
    always_comb begin
        tmo_run_s  = (state_q == ST_CMD) || (state_q == ST_LEN) ||
                     (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
        tmo_d      = '0;
        tmo_fire_s = 1'b0;
        if (tmo_run_s && !rx_valid && !rx_frame_error) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_fire_s = 1'b1;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_fire_s = 1'b0;
`endif

    // Next-state, datapath and error-pulse logic; rx_frame_error outranks rx_valid
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        chk_d       = chk_q;
        frm_avail_d = frm_avail_q;
        frm_cmd_d   = frm_cmd_q;
        frm_len_d   = frm_len_q;
        err_chk_d   = 1'b0;
        err_len_d   = 1'b0;
        err_frame_d = 1'b0;
        err_ovr_d   = 1'b0;
        buf_we_s    = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (rx_frame_error) begin
                    err_frame_d = 1'b1;
                end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
                    state_d = ST_CMD;
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_CMD: begin
                if (rx_frame_error || tmo_fire_s) begin
                    err_frame_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_valid) begin
                    cmd_d   = rx_data;
                    chk_d   = rx_data;
                    state_d = ST_LEN;
                end else begin
                    state_d = ST_CMD;
                end
            end
            ST_LEN: begin
                if (rx_frame_error || tmo_fire_s) begin
                    err_frame_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_valid) begin
                    if (rx_data > 8'(MAX_LEN)) begin
                        err_len_d = 1'b1;
                        state_d   = ST_HUNT;
                    end else begin
                        len_d   = rx_data[4:0];
                        chk_d   = chk_fold(chk_q, rx_data);
                        cnt_d   = 5'd0;
                        state_d = (rx_data == 8'd0) ? ST_CHK : ST_PAYLOAD;
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_PAYLOAD: begin
                if (rx_frame_error || tmo_fire_s) begin
                    err_frame_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_valid) begin
                    buf_we_s = 1'b1;
                    chk_d    = chk_fold(chk_q, rx_data);
                    cnt_d    = cnt_q + 5'd1;
                    state_d  = ((cnt_q + 5'd1) == len_q) ? ST_CHK : ST_PAYLOAD;
                end else begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_CHK: begin
                if (rx_frame_error || tmo_fire_s) begin
                    err_frame_d = 1'b1;
                    state_d     = ST_HUNT;
                end else if (rx_valid) begin
                    if (rx_data == chk_q) begin
                        frm_avail_d = 1'b1;
                        frm_cmd_d   = cmd_q;
                        frm_len_d   = len_q;
                        state_d     = ST_HOLD;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = ST_HUNT;
                    end
                end else begin
                    state_d = ST_CHK;
                end
            end
            ST_HOLD: begin
                // An ack releases the frame, so a byte arriving with it belongs to the hunt
                if (frm_ack) begin
                    frm_avail_d = 1'b0;
                    if (rx_frame_error) begin
                        err_frame_d = 1'b1;
                        state_d     = ST_HUNT;
                    end else if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_d = ST_CMD;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end else if (rx_frame_error) begin
                    err_frame_d = 1'b1;
                end else if (rx_valid) begin
                    err_ovr_d = 1'b1;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_HUNT;
                frm_avail_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            cmd_q       <= 8'h00;
            len_q       <= 5'd0;
            cnt_q       <= 5'd0;
            chk_q       <= '0;
            frm_avail_q <= 1'b0;
            frm_cmd_q   <= 8'h00;
            frm_len_q   <= 5'd0;
            err_chk_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_frame_q <= 1'b0;
            err_ovr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            chk_q       <= chk_d;
            frm_avail_q <= frm_avail_d;
            frm_cmd_q   <= frm_cmd_d;
            frm_len_q   <= frm_len_d;
            err_chk_q   <= err_chk_d;
            err_len_q   <= err_len_d;
            err_frame_q <= err_frame_d;
            err_ovr_q   <= err_ovr_d;
        end
    end

    uart_frame_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (buf_we_s),
        .waddr (cnt_q[3:0]),
        .wdata (rx_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    assign frm_avail = frm_avail_q;
    assign frm_cmd   = frm_cmd_q;
    assign frm_len   = frm_len_q;
    assign err_chk   = err_chk_q;
    assign err_len   = err_len_q;
    assign err_frame = err_frame_q;
    assign err_ovr   = err_ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames then randomized frame traffic.
// Timeout scenario runs only when UART_PARSER_TIMEOUT_EN is defined.
module tb_uart_frame_parser;
    import uart_pkg::*;

    localparam logic [7:0] SYNC = 8'hAA;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_error;
    logic       frm_avail;
    logic [7:0] frm_cmd;
    logic [4:0] frm_len;
    logic       frm_ack;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       err_chk, err_len, err_frame, err_ovr;

    always #10 clk = ~clk;

    uart_frame_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_frame_error(rx_frame_error), .frm_avail(frm_avail), .frm_cmd(frm_cmd),
        .frm_len(frm_len), .frm_ack(frm_ack), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_chk(err_chk), .err_len(err_len), .err_frame(err_frame), .err_ovr(err_ovr)
    );

    typedef enum int {EV_FRAME = 0, EV_CHK = 1, EV_LEN = 2, EV_FERR = 3, EV_OVR = 4} ev_kind_e;
    typedef struct {
        ev_kind_e   kind;
        logic [7:0] cmd;
        logic [4:0] len;
    } ev_t;

    ev_t        sb_q[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_pl [16];
    bit         skip_sync = 1'b0;
    logic       avail_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_ev(input ev_kind_e kind, input logic [7:0] cmd, input logic [4:0] len);
        ev_t e;
        e.kind = kind;
        e.cmd  = cmd;
        e.len  = len;
        sb_q.push_back(e);
    endtask

    task automatic pop_expect(input ev_kind_e kind);
        ev_t e;
        if (sb_q.size() == 0) begin
            check("sb_unexpected_event", kind, 32'hFF);
        end else begin
            e = sb_q.pop_front();
            check("ev_kind", kind, e.kind);
            if (kind == EV_FRAME && e.kind == EV_FRAME) begin
                check("frm_cmd", frm_cmd, e.cmd);
                check("frm_len", frm_len, e.len);
            end
        end
    endtask

    // Monitor: every error pulse or rising frm_avail consumes one scoreboard entry
    task automatic mon_step();
        int n;
        if (!rst_n) begin
            avail_prev <= 1'b0;
        end else begin
            n = int'(err_chk) + int'(err_len) + int'(err_frame) + int'(err_ovr);
            if (n > 1)       check("err_onehot", n, 1);
            else if (err_chk)   pop_expect(EV_CHK);
            else if (err_len)   pop_expect(EV_LEN);
            else if (err_frame) pop_expect(EV_FERR);
            else if (err_ovr)   pop_expect(EV_OVR);
            if (frm_avail && !avail_prev) pop_expect(EV_FRAME);
            avail_prev <= frm_avail;
        end
    endtask

    always @(negedge clk) mon_step();

    task automatic send_byte(input logic [7:0] b, input bit gap);
        @(posedge clk); #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        if (gap) repeat ($urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic pulse_ferr();
        @(posedge clk); #1;
        rx_frame_error = 1'b1;
        @(posedge clk); #1;
        rx_frame_error = 1'b0;
    endtask

    // variant: 0 good, 1 bad checksum (aux = xor corruption), 2 frame error after aux bytes, 3 bad length
    // hold_ops: bit0 overrun byte, bit1 frame error in hold, bit2 ack together with a SYNC byte
    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] len, input int variant,
                            input logic [7:0] aux, input int hold_ops);
        logic [7:0] c;
        int         l;
        l = int'(len);
        if (!skip_sync) send_byte(SYNC, 1'b1);
        skip_sync = 1'b0;
        if (variant == 3) begin
            send_byte(cmd, 1'b1);
            push_ev(EV_LEN, 8'h00, 5'd0);
            send_byte(len, 1'b1);
        end else if (variant == 2) begin
            if (aux >= 8'd1) send_byte(cmd, 1'b1);
            if (aux >= 8'd2) send_byte(len, 1'b1);
            for (int i = 0; i < l && i + 2 < int'(aux); i++) send_byte(exp_pl[i], 1'b1);
            push_ev(EV_FERR, 8'h00, 5'd0);
            pulse_ferr();
        end else begin
            c = cmd ^ len;
            send_byte(cmd, 1'b1);
            send_byte(len, 1'b1);
            for (int i = 0; i < l; i++) begin
                c = c ^ exp_pl[i];
                send_byte(exp_pl[i], 1'b1);
            end
            if (variant == 1) begin
                push_ev(EV_CHK, 8'h00, 5'd0);
                send_byte(c ^ aux, 1'b1);
                check("avail_after_badchk", frm_avail, 1'b0);
            end else begin
                push_ev(EV_FRAME, cmd, len[4:0]);
                send_byte(c, 1'b0);
                check("avail_after_chk", frm_avail, 1'b1);
                for (int i = 0; i < l; i++) begin
                    @(posedge clk); #1;
                    rd_addr = 4'(i);
                    @(posedge clk); #1;
                    check("rd_data", rd_data, exp_pl[i]);
                end
                if ((hold_ops & 1) != 0) begin
                    push_ev(EV_OVR, 8'h00, 5'd0);
                    send_byte(8'($urandom), 1'b1);
                    check("hold_avail_ovr", frm_avail, 1'b1);
                    check("hold_cmd_ovr", frm_cmd, cmd);
                    check("hold_len_ovr", frm_len, len[4:0]);
                    if (l > 0) check("hold_rd_ovr", rd_data, exp_pl[l-1]);
                end
                if ((hold_ops & 2) != 0) begin
                    push_ev(EV_FERR, 8'h00, 5'd0);
                    pulse_ferr();
                    check("hold_avail_ferr", frm_avail, 1'b1);
                end
                @(posedge clk); #1;
                frm_ack = 1'b1;
                if ((hold_ops & 4) != 0) begin
                    rx_valid  = 1'b1;
                    rx_data   = SYNC;
                    skip_sync = 1'b1;
                end
                @(posedge clk); #1;
                frm_ack  = 1'b0;
                rx_valid = 1'b0;
                check("avail_after_ack", frm_avail, 1'b0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_avail"}, frm_avail, 1'b0);
        check({tag, "_cmd"}, frm_cmd, 8'h00);
        check({tag, "_len"}, frm_len, 5'd0);
        check({tag, "_rd"}, rd_data, 8'h00);
        check({tag, "_errs"}, {err_chk, err_len, err_frame, err_ovr}, 4'b0000);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int l;
        rst_n = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; rx_frame_error = 1'b0;
        frm_ack = 1'b0; rd_addr = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Directed scenarios
        exp_pl[0] = 8'h10; exp_pl[1] = 8'h20;
        do_frame(8'h01, 8'h02, 0, 8'h00, 0);
        do_frame(8'h01, 8'h02, 1, 8'h07, 0);
        do_frame(8'h01, 8'h02, 0, 8'h00, 0);
        do_frame(8'h05, 8'h11, 3, 8'h00, 0);
        do_frame(8'h07, 8'h00, 0, 8'h00, 0);
        do_frame(8'h01, 8'h02, 0, 8'h00, 1);
        do_frame(8'h01, 8'h02, 2, 8'h01, 0);
        do_frame(8'h03, 8'h02, 0, 8'h00, 6);
        do_frame(8'h04, 8'h01, 0, 8'h00, 0);

        // Reset in the middle of a payload
        send_byte(SYNC, 1'b1); send_byte(8'h01, 1'b1); send_byte(8'h04, 1'b1);
        send_byte(8'h10, 1'b1); send_byte(8'h20, 1'b1);
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        exp_pl[0] = 8'h5A;
        do_frame(8'h09, 8'h01, 0, 8'h00, 0);

`ifdef UART_PARSER_TIMEOUT_EN
        send_byte(SYNC, 1'b1);
        send_byte(8'h01, 1'b1);
        push_ev(EV_FERR, 8'h00, 5'd0);
        repeat (50010) @(posedge clk);
        do_frame(8'h02, 8'h00, 0, 8'h00, 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            v = $urandom_range(0, 9);
            l = $urandom_range(0, 16);
            for (int i = 0; i < 16; i++) exp_pl[i] = 8'($urandom);
            if (v <= 5)
                do_frame(8'($urandom), 8'(l), 0, 8'h00, $urandom_range(0, 7));
            else if (v == 6)
                do_frame(8'($urandom), 8'(l), 1, 8'($urandom_range(1, 255)), 0);
            else if (v == 7)
                do_frame(8'($urandom), 8'(l), 2, 8'($urandom_range(0, l + 2)), 0);
            else if (v == 8)
                do_frame(8'($urandom), 8'($urandom_range(17, 255)), 3, 8'h00, 0);
            else if (!skip_sync) begin
                send_byte(8'($urandom_range(0, 169)), 1'b1);
                push_ev(EV_FERR, 8'h00, 5'd0);
                pulse_ferr();
            end else begin
                do_frame(8'($urandom), 8'(l), 0, 8'h00, 0);
            end
        end

        repeat (10) @(posedge clk);
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
